// File: rtl/path_replayer.sv
`default_nettype none
// ============================================================================
// Module   : path_replayer
// Purpose  : Maze-solver path stack with an in-order, non-destructive replay
//            reader that streams stored locations over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module path_replayer #(
    parameter int LOC_W = 8,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [LOC_W-1:0] pushLoc,
    output logic [LOC_W-1:0] topLoc,
    output logic             empStck,
    output logic             fullStck,
    output logic             ovf,
    input  logic             clr,
    input  logic             run,
    output logic [LOC_W-1:0] outLoc,
    output logic             outValid,
    input  logic             outReady,
    output logic             replayDone,
    output logic             busy
);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_SEND = 2'd1;
    localparam logic [1:0] C_FIN  = 2'd2;
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_ONE   = (AW+1)'(1);

    logic [LOC_W-1:0] mem_q [DEPTH];

    logic [1:0]       state_q, state_d;
    logic [AW:0]      sp_q, sp_d;
    logic [AW:0]      idx_q, idx_d;
    logic             ovf_q, ovf_d;
    logic [LOC_W-1:0] out_loc_q, out_loc_d;
    logic             out_valid_q, out_valid_d;

    logic             w_empty;
    logic             w_full;
    logic [AW-1:0]    w_top_addr;
    logic [AW:0]      w_idx_nxt;
    logic [AW-1:0]    w_idx_nxt_addr;
    logic             w_mem_we;
    logic [AW-1:0]    w_mem_waddr;

    assign w_empty        = (sp_q == '0);
    assign w_full         = (sp_q == C_DEPTH);
    assign w_top_addr     = AW'(sp_q - C_ONE);
    assign w_idx_nxt      = idx_q + C_ONE;
    assign w_idx_nxt_addr = AW'(w_idx_nxt);

    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        idx_d       = idx_q;
        ovf_d       = ovf_q;
        out_loc_d   = out_loc_q;
        out_valid_d = out_valid_q;
        w_mem_we    = 1'b0;
        w_mem_waddr = AW'(sp_q);

        case (state_q)
            C_IDLE: begin
                if (clr) begin
                    sp_d  = '0;
                    ovf_d = 1'b0;
                end else if (push && pop && !w_empty) begin
                    // Simultaneous push/pop replaces the top entry in place.
                    w_mem_we    = 1'b1;
                    w_mem_waddr = w_top_addr;
                end else if (push) begin
                    if (w_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        w_mem_we = 1'b1;
                        sp_d     = sp_q + C_ONE;
                    end
                end else if (pop) begin
                    if (w_empty) begin
                        ovf_d = 1'b1;
                    end else begin
                        sp_d = sp_q - C_ONE;
                    end
                end

                if (run && !clr) begin
                    idx_d = '0;
                    if (w_empty) begin
                        state_d = C_FIN;
                    end else begin
                        state_d     = C_SEND;
                        out_loc_d   = mem_q[0];
                        out_valid_d = 1'b1;
                    end
                end
            end
            C_SEND: begin
                if (out_valid_q && outReady) begin
                    if (w_idx_nxt < sp_q) begin
                        idx_d     = w_idx_nxt;
                        out_loc_d = mem_q[w_idx_nxt_addr];
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = C_FIN;
                    end
                end
            end
            C_FIN: begin
                state_d = C_IDLE;
            end
            default: begin
                state_d     = C_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= C_IDLE;
            sp_q        <= '0;
            idx_q       <= '0;
            ovf_q       <= 1'b0;
            out_loc_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            idx_q       <= idx_d;
            ovf_q       <= ovf_d;
            out_loc_q   <= out_loc_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Storage carries no reset; contents are meaningless until pushed.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[w_mem_waddr] <= pushLoc;
        end
    end

    assign topLoc     = w_empty ? '0 : mem_q[w_top_addr];
    assign empStck    = w_empty;
    assign fullStck   = w_full;
    assign ovf        = ovf_q;
    assign outLoc     = out_loc_q;
    assign outValid   = out_valid_q;
    assign replayDone = (state_q == C_FIN);
    assign busy       = (state_q != C_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_path_replayer.sv
`default_nettype none
// ============================================================================
// Module   : tb_path_replayer
// Purpose  : Self-checking bench for path_replayer against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_path_replayer;

    localparam int C_DEPTH = 256;

    logic       clk;
    logic       rst;
    logic       push;
    logic       pop;
    logic [7:0] pushLoc;
    logic [7:0] topLoc;
    logic       empStck;
    logic       fullStck;
    logic       ovf;
    logic       clr;
    logic       run;
    logic [7:0] outLoc;
    logic       outValid;
    logic       outReady;
    logic       replayDone;
    logic       busy;

    int vectors;
    int miscompares;

    logic [7:0] model_q[$];
    logic       model_ovf;

    path_replayer #(.LOC_W(8), .DEPTH(C_DEPTH), .AW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .pushLoc    (pushLoc),
        .topLoc     (topLoc),
        .empStck    (empStck),
        .fullStck   (fullStck),
        .ovf        (ovf),
        .clr        (clr),
        .run        (run),
        .outLoc     (outLoc),
        .outValid   (outValid),
        .outReady   (outReady),
        .replayDone (replayDone),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stack(input string tag);
        int n;
        n = model_q.size();
        check({tag, "_top"}, topLoc, (n > 0) ? model_q[n-1] : 8'h00);
        check({tag, "_emp"}, empStck, n == 0);
        check({tag, "_full"}, fullStck, n == C_DEPTH);
        check({tag, "_ovf"}, ovf, model_ovf);
    endtask

    // One idle-state stack operation, applied to both DUT and model.
    task automatic stack_op(input logic p, input logic o, input logic c, input logic [7:0] loc);
        int n;
        push = p; pop = o; clr = c; pushLoc = loc;
        step();
        push = 0; pop = 0; clr = 0;
        n = model_q.size();
        if (c) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else if (p && o && n > 0) begin
            model_q[n-1] = loc;
        end else if (p) begin
            if (n < C_DEPTH) model_q.push_back(loc);
            else model_ovf = 1'b1;
        end else if (o) begin
            if (n > 0) void'(model_q.pop_back());
            else model_ovf = 1'b1;
        end
    endtask

    // mode 0: always ready, 1: ready toggles, 2: random ready plus stack noise while busy
    task automatic replay(input int mode, input string tag);
        logic [7:0] exp_q[$];
        int   k;
        int   n;
        int   c;
        bit   done;
        bit   acc;
        logic rdy;
        exp_q = model_q;
        n = exp_q.size();
        k = 0;
        done = 0;
        run = 1'b1;
        step();
        run = 1'b0;
        for (c = 0; c < 4 * n + 20; c++) begin
            check({tag, "_valid"}, outValid, k < n);
            if (outValid && k < n) check({tag, "_loc"}, outLoc, exp_q[k]);
            if (replayDone) begin
                check({tag, "_count"}, k, n);
                if (mode == 0) check({tag, "_lat"}, c, n);
                done = 1;
                break;
            end
            check({tag, "_busy"}, busy, 1'b1);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (c % 2) == 0;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            outReady = rdy;
            if (mode == 2) begin
                push    = 1'($urandom);
                pop     = 1'($urandom);
                clr     = 1'($urandom);
                run     = 1'($urandom);
                pushLoc = 8'($urandom);
            end
            acc = outValid && rdy;
            step();
            if (acc) k++;
        end
        push = 0; pop = 0; clr = 0; run = 0; outReady = 0;
        if (!done) check({tag, "_timeout"}, 0, 1);
        step();
        check({tag, "_done_pulse"}, replayDone, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
        check_stack({tag, "_post"});
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        model_ovf = 1'b0;
        rst = 1'b0;
        push = 0; pop = 0; clr = 0; run = 0; outReady = 0; pushLoc = 8'h00;

        repeat (2) step();
        check("rst_outloc", outLoc, 8'h00);
        check("rst_valid", outValid, 1'b0);
        check("rst_done", replayDone, 1'b0);
        check("rst_busy", busy, 1'b0);
        check_stack("rst");
        rst = 1'b1;
        step();

        // Basic route, streamed back-to-back then with stalls.
        stack_op(1, 0, 0, 8'h00);
        stack_op(1, 0, 0, 8'h01);
        stack_op(1, 0, 0, 8'h11);
        check_stack("t2_push");
        replay(0, "t2");
        replay(1, "t3");
        replay(2, "t3r");

        // Pop then in-place replacement of the top.
        stack_op(0, 1, 0, 8'h00);
        stack_op(1, 1, 0, 8'hAA);
        check_stack("t4");
        replay(0, "t4");

        // Underflow, clear, overflow.
        stack_op(0, 0, 1, 8'h00);
        stack_op(0, 1, 0, 8'h00);
        check_stack("t5_under");
        stack_op(0, 0, 1, 8'h00);
        check_stack("t5_clr");
        stack_op(1, 1, 0, 8'h5C);
        check_stack("t5_pp_empty");
        for (int i = 1; i < C_DEPTH; i++) stack_op(1, 0, 0, 8'($urandom));
        check_stack("t5_fill");
        stack_op(1, 0, 0, 8'hEE);
        check_stack("t5_over");
        replay(2, "t5");

        // Empty replay.
        stack_op(0, 0, 1, 8'h00);
        replay(0, "t6");

        // Randomized idle operation bursts followed by replays.
        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < 25; j++) begin
                int sel;
                sel = $urandom_range(0, 19);
                stack_op(sel < 12 || sel == 18, (sel >= 12 && sel < 17) || sel == 18,
                         sel == 19, 8'($urandom));
            end
            check_stack("rnd_ops");
            replay(r % 3, "rnd");
        end

        // Asynchronous reset in the middle of a replay.
        stack_op(1, 0, 0, 8'h21);
        stack_op(1, 0, 0, 8'h22);
        run = 1'b1;
        step();
        run = 1'b0;
        check("t1_started", outValid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("t1_outloc", outLoc, 8'h00);
        check("t1_valid", outValid, 1'b0);
        check("t1_busy", busy, 1'b0);
        check("t1_done", replayDone, 1'b0);
        model_q.delete();
        model_ovf = 1'b0;
        check_stack("t1");
        step();
        rst = 1'b1;
        step();
        check_stack("t1_rel");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
